lib_thresh_qual_det: RTL



---
 rtl/lib_thresh_qual_det_pkg.sv | 14 +
 rtl/lib_thresh_qual_det.sv | 101 ++++++++++
 2 files changed

// File: rtl/lib_thresh_qual_det_pkg.sv
// Shared state encoding for the threshold detector family.
// Other detector stages reuse these names so debug views line up across the chain.
package lib_thresh_qual_det_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_REFRACT = 2'd3
    } det_state_t;

endpackage

// File: rtl/lib_thresh_qual_det.sv
// Qualified threshold detector: QUAL_N consecutive valid samples above thr_hi_i raise det_o,
// a sample below thr_lo_i drops it, then REFRACT_N valid samples are ignored.
module lib_thresh_qual_det
    import lib_thresh_qual_det_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int QUAL_N    = 4,
    parameter int REFRACT_N = 50,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic [DATA_W-1:0] thr_hi_i,
    input  logic [DATA_W-1:0] thr_lo_i,
    output logic              det_o,
    output logic              det_pulse_o,
    output logic [1:0]        state_o
);

    localparam logic [CNT_W-1:0] QUAL_TERM    = CNT_W'(QUAL_N);
    localparam logic [CNT_W-1:0] REFRACT_TERM = CNT_W'(REFRACT_N);

    // Stream is valid-only: a sample is consumed on every clock edge where
    // sample_valid_i is high; there is no backpressure. Invalid cycles freeze the FSM.
    det_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             above;
    logic             below;

    assign above   = $signed(sample_i) > $signed(thr_hi_i);
    assign below   = $signed(sample_i) < $signed(thr_lo_i);
    assign cnt_inc = cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            det_o       <= 1'b0;
            det_pulse_o <= 1'b0;
        end else begin
            det_pulse_o <= 1'b0;
            if (sample_valid_i) begin
                case (state)
                    ST_IDLE: begin
                        if (above) begin
                            if (QUAL_N == 1) begin
                                state       <= ST_ACTIVE;
                                cnt         <= '0;
                                det_o       <= 1'b1;
                                det_pulse_o <= 1'b1;
                            end else begin
                                state <= ST_QUAL;
                                cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    ST_QUAL: begin
                        if (!above) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else if (cnt_inc == QUAL_TERM) begin
                            state       <= ST_ACTIVE;
                            cnt         <= '0;
                            det_o       <= 1'b1;
                            det_pulse_o <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_ACTIVE: begin
                        if (below) begin
                            state <= (REFRACT_N == 0) ? ST_IDLE : ST_REFRACT;
                            cnt   <= '0;
                            det_o <= 1'b0;
                        end
                    end
                    ST_REFRACT: begin
                        // Sample values are irrelevant here; only the count matters.
                        if (cnt_inc == REFRACT_TERM) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        det_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state_o = state;

endmodule
